// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: data-memory handshake, upstream stall, branch resolve, MEM/WB register.
// Optional wait-state timeout with sticky error when MEM_TIMEOUT_EN is defined.
module mem_stage_unit #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              CLK_i,
    input  logic              RST_i,
    input  logic [DATA_W-1:0] PCInst_i,
    input  logic [1:0]        WBackVector_i,
    input  logic              memRead_i,
    input  logic              memWrite_i,
    input  logic              branchBit_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [DATA_W-1:0] outALU_i,
    input  logic              aluZero_i,
    input  logic [DATA_W-1:0] dataSrc2_i,
    input  logic [4:0]        regDest_i,
    output logic              dmemReq_o,
    output logic              dmemWe_o,
    output logic [DATA_W-1:0] dmemAddr_o,
    output logic [DATA_W-1:0] dmemWData_o,
    input  logic              dmemAck_i,
    input  logic [DATA_W-1:0] dmemRData_i,
    output logic              stall_o,
    output logic              branchTaken_o,
    output logic [DATA_W-1:0] branchTarget_o,
    output logic [1:0]        WBackVector_o,
    output logic [DATA_W-1:0] memData_o,
    output logic [DATA_W-1:0] aluResult_o,
    output logic [4:0]        regDest_o,
    output logic              memErr_o
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t state_q, state_d;
    logic   access;
    logic   abandon;
    logic   unused_imm_msbs;

    assign access      = memRead_i | memWrite_i;
    assign dmemReq_o   = access & ~RST_i;
    assign dmemWe_o    = memWrite_i;
    assign dmemAddr_o  = outALU_i;
    assign dmemWData_o = dataSrc2_i;

    assign branchTaken_o   = branchBit_i & aluZero_i & ~stall_o & ~RST_i;
    assign branchTarget_o  = PCInst_i + {imm_i[DATA_W-3:0], 2'b00};
    assign unused_imm_msbs = ^imm_i[DATA_W-1:DATA_W-2];

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
`endif

    always_comb begin
        state_d = state_q;
        abandon = 1'b0;
`ifdef MEM_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (access && !dmemAck_i) state_d = S_WAIT;
            end
            S_WAIT: begin
`ifdef MEM_TIMEOUT_EN
                // the IDLE entry cycle is the first wait cycle, so WAIT holds TIMEOUT_CYC-1 more
                if (access && !dmemAck_i && cnt_q == CNT_W'(TIMEOUT_CYC - 1)) abandon = 1'b1;
`endif
                if (!access || dmemAck_i || abandon) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        stall_o = access & ~dmemAck_i & ~abandon & ~RST_i;
`ifdef MEM_TIMEOUT_EN
        cnt_d = (state_q == S_WAIT && state_d == S_WAIT) ? cnt_q + CNT_W'(1) : '0;
        if (abandon) err_d = 1'b1;
`endif
    end

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign memErr_o = err_q;
`else
    assign memErr_o = 1'b0;
`endif

    // A stalled instruction leaves a bubble so write-back never sees it twice.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            WBackVector_o <= '0;
            memData_o     <= '0;
            aluResult_o   <= '0;
            regDest_o     <= '0;
        end else if (stall_o) begin
            WBackVector_o <= '0;
            memData_o     <= '0;
            aluResult_o   <= '0;
            regDest_o     <= '0;
        end else begin
            WBackVector_o <= WBackVector_i;
            memData_o     <= (memRead_i && !memWrite_i && dmemAck_i) ? dmemRData_i : '0;
            aluResult_o   <= outALU_i;
            regDest_o     <= regDest_i;
        end
    end

endmodule
